fifo_head_ctrl: RTL and testbench

Read-side controller for the 4-entry register FIFO; the counterpart of the tail (write) pointer controller. Owns the head pointer, the occupancy count and the full/empty/valid status, and accepts pop requests from the downstream consumer. The write-side controller consumes its fifo_full output; the storage mux reads entry curr_head.

---
 rtl/fifo_head_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fifo_head_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_head_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_head_ctrl
// Description : Read-side controller for the 4-entry register FIFO. Owns the
//               head pointer, occupancy count and full/empty/valid status,
//               and accepts pop requests from the downstream consumer.
//
//   Ports
//     clk             clock, all state updates on the rising edge
//     rst             synchronous active-high reset
//     data_in_valid   producer write request (also drives the tail controller)
//     data_out_ready  consumer pop request
//     curr_head       index of the oldest entry (storage read address)
//     fifo_full       occupancy == DEPTH
//     fifo_empty      occupancy == 0
//     data_out_valid  entry at curr_head holds valid data
//     occupancy       number of valid entries, 0..DEPTH
//     err_overflow    sticky: write request seen while full
//     err_underflow   sticky: pop request seen while empty
//
//   Build option
//     FIFO_ERR_FLAG_EN  when defined, err_overflow/err_underflow are live
//                       sticky registers; otherwise they are tied to 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module fifo_head_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in_valid,
    input  logic             data_out_ready,
    output logic [PTR_W-1:0] curr_head,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             data_out_valid,
    output logic [CNT_W-1:0] occupancy,
    output logic             err_overflow,
    output logic             err_underflow
);

    // State encoding
    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PARTIAL = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_almost = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] w_head_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    logic w_is_full;
    logic w_is_empty;
    logic w_push;
    logic w_pop;

    // Status is decoded from the registered state only, so requests are
    // qualified against this cycle's status and there is no input-to-output
    // combinational path.
    assign w_is_full  = (r_state == S_FULL);
    assign w_is_empty = (r_state == S_EMPTY);
    assign w_push     = data_in_valid  & ~w_is_full;
    assign w_pop      = data_out_ready & ~w_is_empty;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, pointer and count logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_count_nxt = r_count;

        // Pointer wraps naturally at DEPTH because PTR_W = log2(DEPTH).
        if (w_pop) begin
            w_head_nxt = r_head + c_ptr_one;
        end

        // Push and pop together leave the count unchanged.
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_cnt_one;
        end

        case (r_state)
            S_EMPTY: begin
                // A pop cannot be accepted here; any concurrent pop request
                // is ignored while the push goes through.
                if (w_push) begin
                    w_state_nxt = S_PARTIAL;
                end
            end
            S_PARTIAL: begin
                if (w_push && !w_pop && (r_count == c_cnt_almost)) begin
                    w_state_nxt = S_FULL;
                end else if (w_pop && !w_push && (r_count == c_cnt_one)) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                // A concurrent push is already rejected by w_push.
                if (w_pop) begin
                    w_state_nxt = S_PARTIAL;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean empty FIFO.
                w_state_nxt = S_EMPTY;
                w_head_nxt  = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign curr_head      = r_head;
    assign occupancy      = r_count;
    assign fifo_full      = w_is_full;
    assign fifo_empty     = w_is_empty;
    assign data_out_valid = ~w_is_empty;

    // ------------------------------------------------------------------------
    // Optional sticky error flags (observation only, never feed back)
    // ------------------------------------------------------------------------
`ifdef FIFO_ERR_FLAG_EN
    logic r_err_overflow;
    logic r_err_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (data_in_valid && w_is_full) begin
                r_err_overflow <= 1'b1;
            end
            if (data_out_ready && w_is_empty) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_head_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_head_ctrl
// Description : Directed bench for fifo_head_ctrl. Each step drives the
//               request inputs, advances a small occupancy/head model and
//               queues the expected post-edge outputs; after the edge the
//               queued entry is popped and compared against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_head_ctrl;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             data_in_valid;
    logic             data_out_ready;
    logic [PTR_W-1:0] curr_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             data_out_valid;
    logic [CNT_W-1:0] occupancy;
    logic             err_overflow;
    logic             err_underflow;

    fifo_head_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_valid  (data_in_valid),
        .data_out_ready (data_out_ready),
        .curr_head      (curr_head),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .data_out_valid (data_out_valid),
        .occupancy      (occupancy),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int head;
        int cnt;
        int ovf;
        int udf;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_head = 0;
    int m_cnt  = 0;
    int m_ovf  = 0;
    int m_udf  = 0;

`ifdef FIFO_ERR_FLAG_EN
    localparam int c_flags_on = 1;
`else
    localparam int c_flags_on = 0;
`endif

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, predict the result, and check it after the edge.
    task automatic step(input logic r, input logic wv, input logic rr, input string tag);
        exp_t e;
        bit   push;
        bit   pop;
        rst            = r;
        data_in_valid  = wv;
        data_out_ready = rr;
        if (r) begin
            m_head = 0;
            m_cnt  = 0;
            m_ovf  = 0;
            m_udf  = 0;
        end else begin
            if (c_flags_on != 0 && wv && m_cnt == DEPTH) m_ovf = 1;
            if (c_flags_on != 0 && rr && m_cnt == 0)     m_udf = 1;
            push = wv && (m_cnt != DEPTH);
            pop  = rr && (m_cnt != 0);
            m_cnt = m_cnt + int'(push) - int'(pop);
            if (pop) m_head = (m_head + 1) % DEPTH;
        end
        e.head = m_head;
        e.cnt  = m_cnt;
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".head"},  int'(curr_head),      e.head);
            check({tag, ".occ"},   int'(occupancy),      e.cnt);
            check({tag, ".empty"}, int'(fifo_empty),     int'(e.cnt == 0));
            check({tag, ".full"},  int'(fifo_full),      int'(e.cnt == DEPTH));
            check({tag, ".valid"}, int'(data_out_valid), int'(e.cnt != 0));
            check({tag, ".ovf"},   int'(err_overflow),   e.ovf);
            check({tag, ".udf"},   int'(err_underflow),  e.udf);
        end
    endtask

    initial begin
        rst            = 1'b1;
        data_in_valid  = 1'b1;
        data_out_ready = 1'b1;

        // Reset held two cycles with both requests active
        step(1'b1, 1'b1, 1'b1, "reset0");
        step(1'b1, 1'b1, 1'b1, "reset1");

        // Fill to full, then one rejected push
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, "fill");
        step(1'b0, 1'b1, 1'b0, "push_when_full");
        step(1'b0, 1'b0, 1'b0, "idle_full");

        // Drain with head wrap, then one rejected pop
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, "drain");
        step(1'b0, 1'b0, 1'b1, "pop_when_empty");

        // Walk head to 3 with occupancy 2
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "prep_push");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, "prep_pop");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, "prep_push2");

        // Simultaneous push and pop in PARTIAL (head 3 -> 0,1,2)
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, "both_partial");

        // Both at FULL, drain, then both at EMPTY
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, "to_full");
        step(1'b0, 1'b1, 1'b1, "both_at_full");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, "to_empty");
        step(1'b0, 1'b1, 1'b1, "both_at_empty");

        // Occupancy 3, head 2, then mid-stream reset with push active
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, "prep_mid");
        step(1'b1, 1'b1, 1'b0, "mid_reset");
        step(1'b0, 1'b0, 1'b0, "post_reset_idle");

        // Short pseudo-random run against the model
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
